// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channels,
// decode-side output channel and redirect input.
//   imem_req_*  : valid/ready request toward instruction memory
//   imem_rsp_*  : valid-only, in-order response from instruction memory
//   redirect_*  : flush and restart fetch at a new PC
//   valid_o/ready_i/pc_o/insn_o : {pc, insn} toward decode
// Modport master is the fetch unit; slave is the memory/decode environment.
interface fetch_unit_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [AWIDTH-1:0] imem_req_addr_o;
  logic              imem_rsp_valid_i;
  logic [DWIDTH-1:0] imem_rsp_data_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              valid_o;
  logic              ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, insn_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, insn_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues in-order requests to
// instruction memory, pairs each returned word with its PC and buffers the
// pairs in a DEPTH-entry FIFO presented to decode. A redirect flushes the
// FIFO and marks every older in-flight response for discard.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset (0 = reset)
//   bus : fetch_unit_if.master (memory request/response, redirect, decode)
module fetch_unit #(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
  parameter int unsigned       DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Architectural and bookkeeping state
  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [PW-1:0]     fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  // Storage (data only, qualified by pointers/counters)
  logic [AWIDTH-1:0] pcq_mem_q  [DEPTH];
  logic [AWIDTH-1:0] fifo_pc_q  [DEPTH];
  logic [DWIDTH-1:0] fifo_insn_q[DEPTH];

  logic              pop_c;
  logic              req_fire_c;
  logic              rsp_take_c;
  logic              rsp_drop_c;
  logic              rsp_push_c;
  logic [CW:0]       credit_used_c;
  logic [CW-1:0]     outst_after_rsp_c;
  logic              fifo_nempty_c;

  assign fifo_nempty_c = (count_q != '0);

  // Decode-side channel; a redirect suppresses delivery in its own cycle
  assign bus.valid_o = rst & fifo_nempty_c & ~bus.redirect_i;
  assign bus.pc_o    = fifo_nempty_c ? fifo_pc_q[fifo_rd_q]   : '0;
  assign bus.insn_o  = fifo_nempty_c ? fifo_insn_q[fifo_rd_q] : '0;
  assign pop_c       = bus.valid_o & bus.ready_i;

  // Credit: every outstanding request owns a FIFO slot, so the FIFO cannot overflow
  assign credit_used_c = (CW+1)'(outst_q) + (CW+1)'(count_q) - (CW+1)'(pop_c);
  assign bus.imem_req_valid_o = rst & ~bus.redirect_i & (credit_used_c < (CW+1)'(DEPTH));
  assign bus.imem_req_addr_o  = fetch_pc_q;
  assign req_fire_c = bus.imem_req_valid_o & bus.imem_req_ready_i;

  // Responses with nothing outstanding are protocol errors and are ignored
  assign rsp_take_c = rst & bus.imem_rsp_valid_i & (outst_q != '0);
  assign rsp_drop_c = rsp_take_c & (drop_q != '0);
  assign rsp_push_c = rsp_take_c & (drop_q == '0) & ~bus.redirect_i;
  assign outst_after_rsp_c = outst_q - CW'(rsp_take_c);

  // Next-state logic
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_after_rsp_c + CW'(req_fire_c);
    drop_d     = drop_q - CW'(rsp_drop_c);
    count_d    = count_q + CW'(rsp_push_c) - CW'(pop_c);
    pcq_wr_d   = pcq_wr_q + PW'(req_fire_c);
    pcq_rd_d   = pcq_rd_q + PW'(rsp_take_c);
    fifo_wr_d  = fifo_wr_q + PW'(rsp_push_c);
    fifo_rd_d  = fifo_rd_q + PW'(pop_c);

    if (req_fire_c) begin
      fetch_pc_d = fetch_pc_q + AWIDTH'(4);
    end

    // Redirect: no request/pop this cycle; all still-outstanding responses are stale
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i & ~AWIDTH'(3);
      drop_d     = outst_after_rsp_c;
      count_d    = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= BASEADDR;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
    end
  end

  // Storage writes
  always_ff @(posedge clk) begin
    if (req_fire_c) begin
      pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
    end
    if (rsp_push_c) begin
      fifo_pc_q[fifo_wr_q]   <= pcq_mem_q[pcq_rd_q];
      fifo_insn_q[fifo_wr_q] <= bus.imem_rsp_data_i;
    end
  end

  // Occupancy sanity checks
  always @(posedge clk) begin
    if (rst) begin
      assert (outst_q <= CW'(DEPTH));
      assert (count_q <= CW'(DEPTH));
      assert (drop_q <= outst_q);
      assert ((CW+1)'(outst_q) + (CW+1)'(count_q) <= (CW+1)'(DEPTH));
    end
  end

endmodule
